// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the boot program loader.
package prog_loader_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ROM_AW_DEF = 10;
    localparam int PM_AW_DEF  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/load_index_ctr.sv
// Word index for the loader; one bit wider than the program-memory address
// so that a full-depth load still has a reachable terminal value.
module load_index_ctr
    import prog_loader_pkg::*;
#(
    parameter int PM_AW      = PM_AW_DEF,
    parameter int LOAD_WORDS = 512
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           inc,
    output logic [PM_AW:0] index,
    output logic           last
);

    localparam logic [PM_AW:0] LAST_IDX = (PM_AW + 1)'(LOAD_WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            index <= '0;
        end else if (inc) begin
            index <= index + 1'b1;
        end
    end

    assign last = (index == LAST_IDX);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: copies LOAD_WORDS words from boot RAM into program memory,
// holding the processor in reset until the copy completes.
//   state | meaning
//   IDLE  | out of reset, starts automatically next cycle
//   FETCH | issue boot RAM read for current index
//   WAIT  | cover RAM latency, capture word on last cycle
//   WRITE | present word to program memory until accepted
//   DONE  | load complete, waiting for restart
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ROM_AW     = ROM_AW_DEF,
    parameter int PM_AW      = PM_AW_DEF,
    parameter int LOAD_WORDS = 512,
    parameter int ROM_BASE   = 0,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk_in,
    input  logic              rst_load,
    input  logic              rst_processor,
    input  logic              start,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              pm_we,
    output logic [PM_AW-1:0]  pm_addr,
    output logic [DATA_W-1:0] pm_data,
    input  logic              pm_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              proc_rst
);

    localparam logic [ROM_AW-1:0] ROM_BASE_A = ROM_AW'(ROM_BASE);
    localparam logic [1:0]        WAIT_LOAD  = 2'(ROM_LAT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      wait_cnt;
    logic [PM_AW:0]  index;
    logic            last;
    logic            idx_clr;
    logic            idx_inc;
    logic            accept;
    logic            restart;

    assign accept  = (state == WRITE) && pm_ready;
    assign restart = (state == DONE) && start;
    assign idx_clr = restart;
    assign idx_inc = accept && !last;

    load_index_ctr #(
        .PM_AW      (PM_AW),
        .LOAD_WORDS (LOAD_WORDS)
    ) u_index (
        .clk   (clk_in),
        .rst   (rst_load),
        .clr   (idx_clr),
        .inc   (idx_inc),
        .index (index),
        .last  (last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: state_nxt = WAIT;
            WAIT:  if (wait_cnt == 2'd0) state_nxt = WRITE;
            WRITE: if (pm_ready) state_nxt = last ? DONE : FETCH;
            DONE:  if (start) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_load) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
            pm_data  <= '0;
            checksum <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == WAIT && wait_cnt == 2'd0) begin
                pm_data <= rom_data;
            end
            if (restart) begin
                checksum <= '0;
            end else if (accept) begin
                checksum <= checksum + pm_data;
            end
        end
    end

    // Address outputs follow the index directly; strobes qualify them.
    assign rom_addr = ROM_BASE_A + ROM_AW'(index);
    assign pm_addr  = index[PM_AW-1:0];
    assign rom_en   = (state == FETCH);
    assign pm_we    = (state == WRITE);
    assign busy     = (state == FETCH) || (state == WAIT) || (state == WRITE);
    assign done     = (state == DONE);
    assign proc_rst = rst_processor | ~done;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a 4-word/latency-1 instance and a 2-word/latency-3
// instance, each fed by a small boot RAM model and checked by write scoreboards.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // instance A: LOAD_WORDS=4, ROM_LAT=1, ROM_BASE=0
    logic        rst_load_a, rst_proc_a, start_a, pm_ready_a;
    logic        rom_en_a, pm_we_a, busy_a, done_a, proc_rst_a;
    logic [9:0]  rom_addr_a;
    logic [8:0]  pm_addr_a;
    logic [15:0] rom_data_a, pm_data_a, checksum_a;

    // instance B: LOAD_WORDS=2, ROM_LAT=3, ROM_BASE=100h
    logic        rst_load_b, rst_proc_b, start_b, pm_ready_b;
    logic        rom_en_b, pm_we_b, busy_b, done_b, proc_rst_b;
    logic [9:0]  rom_addr_b;
    logic [8:0]  pm_addr_b;
    logic [15:0] rom_data_b, pm_data_b, checksum_b;

    prog_loader #(
        .DATA_W(16), .ROM_AW(10), .PM_AW(9),
        .LOAD_WORDS(4), .ROM_BASE(0), .ROM_LAT(1)
    ) dut_a (
        .clk_in(clk), .rst_load(rst_load_a), .rst_processor(rst_proc_a),
        .start(start_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .pm_we(pm_we_a), .pm_addr(pm_addr_a),
        .pm_data(pm_data_a), .pm_ready(pm_ready_a), .busy(busy_a),
        .done(done_a), .checksum(checksum_a), .proc_rst(proc_rst_a)
    );

    prog_loader #(
        .DATA_W(16), .ROM_AW(10), .PM_AW(9),
        .LOAD_WORDS(2), .ROM_BASE(256), .ROM_LAT(3)
    ) dut_b (
        .clk_in(clk), .rst_load(rst_load_b), .rst_processor(rst_proc_b),
        .start(start_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .pm_we(pm_we_b), .pm_addr(pm_addr_b),
        .pm_data(pm_data_b), .pm_ready(pm_ready_b), .busy(busy_b),
        .done(done_b), .checksum(checksum_b), .proc_rst(proc_rst_b)
    );

    // Boot RAM models; out-of-range or idle reads return poison so a
    // mistimed capture shows up as a data error.
    logic [15:0] mem_a [4];
    logic [15:0] mem_b [2];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];

    always @(posedge clk) begin
        pipe_a <= (rom_en_a && rom_addr_a < 10'd4) ? mem_a[rom_addr_a[1:0]] : 16'hDEAD;
    end
    assign rom_data_a = pipe_a;

    always @(posedge clk) begin
        pipe_b[0] <= (rom_en_b && rom_addr_b >= 10'h100 && rom_addr_b <= 10'h101)
                     ? mem_b[rom_addr_b[0]] : 16'hBEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rom_data_b = pipe_b[2];

    int          q_addr_a [$];
    logic [15:0] q_data_a [$];
    int          q_addr_b [$];
    logic [15:0] q_data_b [$];
    int          q_rom_b  [$];
    int          cyc_a, cyc_b;

    // One clock for A: check strobe exclusion and score any write the coming
    // edge will accept, then advance to the next falling edge.
    task automatic tick_a();
        logic        acc;
        int          a, ea;
        logic [15:0] d, ed;
        acc = pm_we_a && pm_ready_a;
        a   = int'(pm_addr_a);
        d   = pm_data_a;
        if (rom_en_a || pm_we_a) begin
            tests_run++;
            if (rom_en_a && pm_we_a) begin
                tests_failed++;
                $display("FAIL a_strobe_excl: rom_en=%b pm_we=%b, required not both", rom_en_a, pm_we_a);
            end
        end
        if (acc) begin
            tests_run++;
            if (q_addr_a.size() == 0) begin
                tests_failed++;
                $display("FAIL a_sb_extra: write addr=%0d data=%h, required no write", a, d);
            end else begin
                ea = q_addr_a.pop_front();
                ed = q_data_a.pop_front();
                if (a !== ea || d !== ed) begin
                    tests_failed++;
                    $display("FAIL a_sb_write: addr=%0d data=%h, required addr=%0d data=%h", a, d, ea, ed);
                end
            end
        end
        @(negedge clk);
        cyc_a++;
    endtask

    task automatic tick_b();
        logic        acc;
        int          a, ea, ra;
        logic [15:0] d, ed;
        acc = pm_we_b && pm_ready_b;
        a   = int'(pm_addr_b);
        d   = pm_data_b;
        if (rom_en_b) begin
            tests_run++;
            if (q_rom_b.size() == 0) begin
                tests_failed++;
                $display("FAIL b_rom_extra: rom_addr=%h, required no read", rom_addr_b);
            end else begin
                ra = q_rom_b.pop_front();
                if (int'(rom_addr_b) !== ra || pm_we_b !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b_rom_addr: rom_addr=%h pm_we=%b, required %h and 0", rom_addr_b, pm_we_b, ra);
                end
            end
        end
        if (acc) begin
            tests_run++;
            if (q_addr_b.size() == 0) begin
                tests_failed++;
                $display("FAIL b_sb_extra: write addr=%0d data=%h, required no write", a, d);
            end else begin
                ea = q_addr_b.pop_front();
                ed = q_data_b.pop_front();
                if (a !== ea || d !== ed) begin
                    tests_failed++;
                    $display("FAIL b_sb_write: addr=%0d data=%h, required addr=%0d data=%h", a, d, ea, ed);
                end
            end
        end
        @(negedge clk);
        cyc_b++;
    endtask

    task automatic push_a();
        q_addr_a.delete();
        q_data_a.delete();
        for (int i = 0; i < 4; i++) begin
            q_addr_a.push_back(i);
            q_data_a.push_back(mem_a[i]);
        end
    endtask

    task automatic push_b();
        q_addr_b.delete();
        q_data_b.delete();
        q_rom_b.delete();
        for (int i = 0; i < 2; i++) begin
            q_addr_b.push_back(i);
            q_data_b.push_back(mem_b[i]);
            q_rom_b.push_back(256 + i);
        end
    endtask

    task automatic run_a(input int limit);
        while (done_a !== 1'b1 && cyc_a < limit) tick_a();
    endtask

    task automatic run_b(input int limit);
        while (done_b !== 1'b1 && cyc_b < limit) tick_b();
    endtask

    task automatic test_reset();
        rst_load_a = 1'b1; rst_load_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        rst_proc_a = 1'b0; rst_proc_b = 1'b0;
        pm_ready_a = 1'b1; pm_ready_b = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy_a, done_a, rom_en_a, pm_we_a, proc_rst_a} !== 5'b00001 ||
            rom_addr_a !== 10'h000 || pm_addr_a !== 9'd0 || pm_data_a !== 16'h0 || checksum_a !== 16'h0) begin
            tests_failed++;
            $display("FAIL a_reset: b/d/re/we/pr=%b%b%b%b%b ra=%h pa=%h pd=%h cs=%h, required 00001 000 0 0 0",
                     busy_a, done_a, rom_en_a, pm_we_a, proc_rst_a, rom_addr_a, pm_addr_a, pm_data_a, checksum_a);
        end
        tests_run++;
        if ({busy_b, done_b, rom_en_b, pm_we_b, proc_rst_b} !== 5'b00001 ||
            rom_addr_b !== 10'h100 || pm_addr_b !== 9'd0 || pm_data_b !== 16'h0 || checksum_b !== 16'h0) begin
            tests_failed++;
            $display("FAIL b_reset: b/d/re/we/pr=%b%b%b%b%b ra=%h pa=%h pd=%h cs=%h, required 00001 100 0 0 0",
                     busy_b, done_b, rom_en_b, pm_we_b, proc_rst_b, rom_addr_b, pm_addr_b, pm_data_b, checksum_b);
        end
    endtask

    task automatic test_basic();
        mem_a[0] = 16'h1111; mem_a[1] = 16'h2222; mem_a[2] = 16'h3333; mem_a[3] = 16'h4444;
        push_a();
        rst_load_a = 1'b0;
        cyc_a = -1;
        run_a(60);
        tests_run++;
        if (cyc_a !== 12 || checksum_a !== 16'hAAAA || proc_rst_a !== 1'b0 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: cycle=%0d cs=%h proc_rst=%b busy=%b, required 12 AAAA 0 0",
                     cyc_a, checksum_a, proc_rst_a, busy_a);
        end
        rst_proc_a = 1'b1;
        #1;
        tests_run++;
        if (proc_rst_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_proc_rst_req: proc_rst=%b, required 1", proc_rst_a);
        end
        rst_proc_a = 1'b0;
        @(negedge clk);
        tests_run++;
        if (q_addr_a.size() !== 0) begin
            tests_failed++;
            $display("FAIL basic_sb_left: %0d writes outstanding, required 0", q_addr_a.size());
        end
    endtask

    task automatic test_backpressure();
        rst_load_a = 1'b1;
        repeat (2) @(negedge clk);
        push_a();
        rst_load_a = 1'b0;
        cyc_a = -1;
        while (done_a !== 1'b1 && cyc_a < 60) begin
            pm_ready_a = !(cyc_a >= 8 && cyc_a < 13);
            if (!pm_ready_a) begin
                tests_run++;
                if (pm_we_a !== 1'b1 || pm_addr_a !== 9'd2 || pm_data_a !== 16'h3333 || checksum_a !== 16'h3333) begin
                    tests_failed++;
                    $display("FAIL bp_hold: cyc=%0d we=%b addr=%0d data=%h cs=%h, required 1 2 3333 3333",
                             cyc_a, pm_we_a, pm_addr_a, pm_data_a, checksum_a);
                end
            end
            tick_a();
        end
        pm_ready_a = 1'b1;
        tests_run++;
        if (cyc_a !== 17 || checksum_a !== 16'hAAAA || q_addr_a.size() !== 0) begin
            tests_failed++;
            $display("FAIL bp_done: cycle=%0d cs=%h left=%0d, required 17 AAAA 0", cyc_a, checksum_a, q_addr_a.size());
        end
    endtask

    task automatic test_rom_lat3();
        mem_b[0] = 16'h1234; mem_b[1] = 16'h5678;
        push_b();
        rst_load_b = 1'b0;
        cyc_b = -1;
        run_b(60);
        tests_run++;
        if (cyc_b !== 10 || checksum_b !== 16'h68AC || proc_rst_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_done: cycle=%0d cs=%h proc_rst=%b, required 10 68AC 0", cyc_b, checksum_b, proc_rst_b);
        end
        tests_run++;
        if (q_addr_b.size() !== 0 || q_rom_b.size() !== 0) begin
            tests_failed++;
            $display("FAIL lat3_sb_left: writes=%0d reads=%0d outstanding, required 0 0", q_addr_b.size(), q_rom_b.size());
        end
    endtask

    task automatic test_checksum_wrap();
        mem_b[0] = 16'hFFFF; mem_b[1] = 16'h0002;
        push_b();
        start_b = 1'b1;
        cyc_b = -1;
        tick_b();
        start_b = 1'b0;
        run_b(60);
        tests_run++;
        if (cyc_b !== 10 || checksum_b !== 16'h0001) begin
            tests_failed++;
            $display("FAIL wrap_checksum: cycle=%0d cs=%h, required 10 0001", cyc_b, checksum_b);
        end
    endtask

    task automatic test_reset_mid();
        rst_load_a = 1'b1;
        repeat (2) @(negedge clk);
        push_a();
        rst_load_a = 1'b0;
        cyc_a = -1;
        while (cyc_a < 6) tick_a();
        rst_load_a = 1'b1;
        tick_a();
        tests_run++;
        if ({busy_a, done_a, rom_en_a, pm_we_a, proc_rst_a} !== 5'b00001 ||
            rom_addr_a !== 10'h000 || pm_addr_a !== 9'd0 || pm_data_a !== 16'h0 || checksum_a !== 16'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_vals: b/d/re/we/pr=%b%b%b%b%b ra=%h pa=%h pd=%h cs=%h, required 00001 000 0 0 0",
                     busy_a, done_a, rom_en_a, pm_we_a, proc_rst_a, rom_addr_a, pm_addr_a, pm_data_a, checksum_a);
        end
        tests_run++;
        if (q_addr_a.size() !== 2) begin
            tests_failed++;
            $display("FAIL mid_partial_writes: %0d outstanding, required 2", q_addr_a.size());
        end
        push_a();
        rst_load_a = 1'b0;
        cyc_a = -1;
        run_a(60);
        tests_run++;
        if (cyc_a !== 12 || checksum_a !== 16'hAAAA || q_addr_a.size() !== 0) begin
            tests_failed++;
            $display("FAIL mid_reload: cycle=%0d cs=%h left=%0d, required 12 AAAA 0", cyc_a, checksum_a, q_addr_a.size());
        end
    endtask

    task automatic test_restart();
        push_a();
        start_a = 1'b1;
        cyc_a = -1;
        tick_a();
        start_a = 1'b0;
        tests_run++;
        if (done_a !== 1'b0 || proc_rst_a !== 1'b1 || busy_a !== 1'b1 || checksum_a !== 16'h0 || rom_en_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_edge: done=%b proc_rst=%b busy=%b cs=%h rom_en=%b, required 0 1 1 0000 1",
                     done_a, proc_rst_a, busy_a, checksum_a, rom_en_a);
        end
        run_a(60);
        tests_run++;
        if (cyc_a !== 12 || checksum_a !== 16'hAAAA || q_addr_a.size() !== 0) begin
            tests_failed++;
            $display("FAIL restart_done: cycle=%0d cs=%h left=%0d, required 12 AAAA 0", cyc_a, checksum_a, q_addr_a.size());
        end
    endtask

    task automatic test_reset_priority();
        rst_load_a = 1'b1;
        start_a = 1'b1;
        tick_a();
        tests_run++;
        if (busy_a !== 1'b0 || rom_en_a !== 1'b0 || done_a !== 1'b0 || checksum_a !== 16'h0) begin
            tests_failed++;
            $display("FAIL rst_over_start: busy=%b rom_en=%b done=%b cs=%h, required 0 0 0 0000",
                     busy_a, rom_en_a, done_a, checksum_a);
        end
        start_a = 1'b0;
        rst_load_a = 1'b0;
        push_a();
        cyc_a = -1;
        while (done_a !== 1'b1 && cyc_a < 60) begin
            start_a = (cyc_a == 4 || cyc_a == 9);
            tick_a();
        end
        start_a = 1'b0;
        tests_run++;
        if (cyc_a !== 12 || checksum_a !== 16'hAAAA || q_addr_a.size() !== 0) begin
            tests_failed++;
            $display("FAIL start_while_busy: cycle=%0d cs=%h left=%0d, required 12 AAAA 0", cyc_a, checksum_a, q_addr_a.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_rom_lat3();
        test_checksum_wrap();
        test_reset_mid();
        test_restart();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
